// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the Mini RISC multi-cycle control unit (master) and
// its datapath (slave): decode inputs, memory handshake, and datapath strobes.
interface multicycle_control_unit_if #(
    parameter int FUNCT_W   = 4,
    parameter int NUM_LANES = 4
);
    logic [5:0]           opcode;
    logic [FUNCT_W-1:0]   funct;
    logic                 mem_ready;
    logic                 resume;
    logic                 pc_stall;
    logic                 reg_write_en;
    logic                 alu_src_sel;
    logic                 reg_dest_sel;
    logic [FUNCT_W-1:0]   alu_op;
    logic                 immediate_sel;
    logic                 move_or_branch;
    logic [NUM_LANES-1:0] mem_write_en;
    logic                 read_enable;
    logic                 halt;
    logic                 halt_now;
    logic                 mem_timeout;
    logic [2:0]           state_out;

    modport master (
        input  opcode, funct, mem_ready, resume,
        output pc_stall, reg_write_en, alu_src_sel, reg_dest_sel, alu_op,
               immediate_sel, move_or_branch, mem_write_en, read_enable,
               halt, halt_now, mem_timeout, state_out
    );

    modport slave (
        output opcode, funct, mem_ready, resume,
        input  pc_stall, reg_write_en, alu_src_sel, reg_dest_sel, alu_op,
               immediate_sel, move_or_branch, mem_write_en, read_enable,
               halt, halt_now, mem_timeout, state_out
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH / EXECUTE / MEM_WAIT / WRITEBACK / HALTED with
// fixed or ready-driven memory latency (optional timeout) and resumable halt.
module multicycle_control_unit #(
    parameter int FUNCT_W   = 4,
    parameter int NUM_LANES = 4,
    parameter int MEM_LAT   = 1,
    parameter int USE_READY = 0,
    parameter int TIMEOUT   = 15
) (
    input logic clk,
    input logic rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_EXECUTE   = 3'd1,
        S_MEM_WAIT  = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam int MAX_CNT = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
    localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam bit HAS_TIMEOUT = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             halt_q, mem_timeout_q, load_q;
    logic             wait_ok, wait_abort;
    logic             is_r, is_ialu, is_br, is_move, is_cmov, is_load, is_store, is_halt;

    assign is_r     = (bus.opcode == 6'b000000);
    assign is_ialu  = (bus.opcode[5:4] == 2'b01);
    assign is_br    = (bus.opcode == 6'b100011);
    assign is_move  = (bus.opcode == 6'b110000);
    assign is_cmov  = (bus.opcode == 6'b110001);
    assign is_load  = (bus.opcode == 6'b101000);
    assign is_store = (bus.opcode == 6'b101001);
    assign is_halt  = (bus.opcode == 6'b111000);

    // Memory handshake: in MEM_WAIT with USE_READY=1, mem_ready=1 completes the
    // access on that edge; mem_ready beats a timeout landing in the same cycle.
    always_comb begin
        wait_ok    = 1'b0;
        wait_abort = 1'b0;
        if (USE_READY == 0) begin
            wait_ok = (cnt_q == LAT_LAST);
        end else begin
            wait_ok    = bus.mem_ready;
            wait_abort = !bus.mem_ready && HAS_TIMEOUT && (cnt_q == TO_LAST);
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.pc_stall        = 1'b0;
        bus.reg_write_en    = 1'b0;
        bus.alu_src_sel     = 1'b0;
        bus.reg_dest_sel    = 1'b0;
        bus.alu_op          = '0;
        bus.immediate_sel   = 1'b0;
        bus.move_or_branch  = 1'b0;
        bus.mem_write_en    = '0;
        bus.read_enable     = 1'b0;
        bus.halt_now        = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.pc_stall = 1'b1;
                state_d      = S_EXECUTE;
            end
            S_EXECUTE: begin
                bus.alu_src_sel    = is_r | is_move | is_cmov;
                bus.reg_dest_sel   = is_r | is_move | is_cmov;
                bus.immediate_sel  = is_br;
                bus.move_or_branch = is_move | is_cmov | is_br;
                if (is_r)
                    bus.alu_op = bus.funct;
                else if (is_ialu)
                    bus.alu_op = FUNCT_W'(bus.opcode[3:0]);
                state_d = S_FETCH;
                if (is_load) begin
                    bus.pc_stall = 1'b1;
                    state_d      = S_MEM_WAIT;
                end else if (is_store) begin
                    bus.mem_write_en = '1;
                    if (USE_READY != 0) begin
                        bus.pc_stall = 1'b1;
                        state_d      = S_MEM_WAIT;
                    end
                end else if (is_halt) begin
                    bus.halt_now = 1'b1;
                    bus.pc_stall = 1'b1;
                    state_d      = S_HALTED;
                end else begin
                    bus.reg_write_en = is_r | is_ialu | is_move | is_cmov;
                end
            end
            S_MEM_WAIT: begin
                bus.pc_stall    = 1'b1;
                bus.read_enable = load_q;
                if (wait_ok)
                    state_d = load_q ? S_WRITEBACK : S_FETCH;
                else if (wait_abort)
                    state_d = S_FETCH;
            end
            S_WRITEBACK: begin
                bus.reg_write_en = 1'b1;
                state_d          = S_FETCH;
            end
            S_HALTED: begin
                bus.pc_stall = 1'b1;
                if (bus.resume)
                    state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            cnt_q         <= '0;
            halt_q        <= 1'b0;
            mem_timeout_q <= 1'b0;
            load_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= (state_q == S_MEM_WAIT && !wait_ok && !wait_abort)
                             ? cnt_q + CNT_W'(1) : '0;
            halt_q        <= (state_d == S_HALTED);
            mem_timeout_q <= (state_q == S_MEM_WAIT) && wait_abort;
            // Class is latched so MEM_WAIT/WRITEBACK do not depend on opcode decode.
            if (state_q == S_EXECUTE && is_load)
                load_q <= 1'b1;
            else if (state_q == S_EXECUTE && is_store)
                load_q <= 1'b0;
        end
    end

    assign bus.halt        = halt_q;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.state_out   = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: one fixed-latency instance (MEM_LAT=3) and one ready-handshake
// instance (TIMEOUT=5), driven by a linear sequence of steps.
module tb_multicycle_control_unit;
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_IALU  = 6'b010111;
    localparam logic [5:0] OP_BR    = 6'b100011;
    localparam logic [5:0] OP_CMOV  = 6'b110001;
    localparam logic [5:0] OP_LOAD  = 6'b101000;
    localparam logic [5:0] OP_STORE = 6'b101001;
    localparam logic [5:0] OP_HALT  = 6'b111000;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   halt_cnt;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.FUNCT_W(4), .NUM_LANES(4)) if_fix ();
    multicycle_control_unit_if #(.FUNCT_W(4), .NUM_LANES(4)) if_rdy ();

    multicycle_control_unit #(.FUNCT_W(4), .NUM_LANES(4), .MEM_LAT(3), .USE_READY(0), .TIMEOUT(15))
        u_fix (.clk(clk), .rst(rst), .bus(if_fix.master));
    multicycle_control_unit #(.FUNCT_W(4), .NUM_LANES(4), .MEM_LAT(1), .USE_READY(1), .TIMEOUT(5))
        u_rdy (.clk(clk), .rst(rst), .bus(if_rdy.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] st, input logic pcs, input logic rwe,
                        input logic [2:0] e_st, input logic e_pcs, input logic e_rwe);
        chk({tag, ".state"}, 32'(st), 32'(e_st));
        chk({tag, ".pc_stall"}, 32'(pcs), 32'(e_pcs));
        chk({tag, ".reg_write_en"}, 32'(rwe), 32'(e_rwe));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        if_fix.opcode = OP_NOP; if_fix.funct = '0; if_fix.mem_ready = 1'b0; if_fix.resume = 1'b0;
        if_rdy.opcode = OP_NOP; if_rdy.funct = '0; if_rdy.mem_ready = 1'b0; if_rdy.resume = 1'b0;
        step();
        step();

        // Reset state
        chk3("reset", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        chk("reset.alu_op", 32'(if_fix.alu_op), 32'h0);
        chk("reset.halt", 32'(if_fix.halt), 32'h0);
        chk("reset.mem_timeout", 32'(if_rdy.mem_timeout), 32'h0);
        chk("reset.mem_write_en", 32'(if_fix.mem_write_en), 32'h0);

        // ADD, I-ALU, CMOV, BR back to back on the fixed instance
        if_fix.opcode = OP_R; if_fix.funct = 4'b0101;
        do_reset();
        chk3("add.fetch", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        step();
        chk3("add.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b1);
        chk("add.alu_op", 32'(if_fix.alu_op), 32'h5);
        chk("add.alu_src_sel", 32'(if_fix.alu_src_sel), 32'h1);
        chk("add.reg_dest_sel", 32'(if_fix.reg_dest_sel), 32'h1);
        chk("add.move_or_branch", 32'(if_fix.move_or_branch), 32'h0);
        step();
        chk3("add.done", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        chk("add.alu_op_fetch", 32'(if_fix.alu_op), 32'h0);
        if_fix.opcode = OP_IALU; if_fix.funct = 4'b1010;
        step();
        chk3("ialu.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b1);
        chk("ialu.alu_op", 32'(if_fix.alu_op), 32'h7);
        chk("ialu.alu_src_sel", 32'(if_fix.alu_src_sel), 32'h0);
        step();
        if_fix.opcode = OP_CMOV;
        step();
        chk3("cmov.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b1);
        chk("cmov.move_or_branch", 32'(if_fix.move_or_branch), 32'h1);
        chk("cmov.reg_dest_sel", 32'(if_fix.reg_dest_sel), 32'h1);
        chk("cmov.alu_op", 32'(if_fix.alu_op), 32'h0);
        step();
        if_fix.opcode = OP_BR;
        step();
        chk3("br.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b0);
        chk("br.immediate_sel", 32'(if_fix.immediate_sel), 32'h1);
        chk("br.move_or_branch", 32'(if_fix.move_or_branch), 32'h1);
        step();

        // LOAD with MEM_LAT=3: 0,1,2,2,2,3,0
        if_fix.opcode = OP_LOAD;
        step();
        chk3("ld.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b1, 1'b0);
        chk("ld.exec_read", 32'(if_fix.read_enable), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("ld.wait", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd2, 1'b1, 1'b0);
            chk("ld.wait_read", 32'(if_fix.read_enable), 32'h1);
        end
        step();
        chk3("ld.wb", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd3, 1'b0, 1'b1);
        chk("ld.wb_read", 32'(if_fix.read_enable), 32'h0);
        chk("ld.wb_dest", 32'(if_fix.reg_dest_sel), 32'h0);
        step();
        chk3("ld.done", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);

        // STORE with fixed latency: single EXECUTE cycle
        if_fix.opcode = OP_STORE;
        step();
        chk3("st_fix.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b0);
        chk("st_fix.lanes", 32'(if_fix.mem_write_en), 32'hF);
        step();
        chk("st_fix.next", 32'(if_fix.state_out), 32'h0);
        chk("st_fix.lanes_off", 32'(if_fix.mem_write_en), 32'h0);
        if_fix.opcode = OP_NOP;

        // Ready instance: LOAD with mem_ready in the 4th MEM_WAIT cycle
        if_rdy.opcode = OP_LOAD;
        do_reset();
        step();
        chk("rl.exec", 32'(if_rdy.state_out), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rl.wait", 32'(if_rdy.state_out), 32'h2);
            chk("rl.read", 32'(if_rdy.read_enable), 32'h1);
            if (i == 3) if_rdy.mem_ready = 1'b1;
        end
        step();
        if_rdy.mem_ready = 1'b0;
        chk3("rl.wb", if_rdy.state_out, if_rdy.pc_stall, if_rdy.reg_write_en, 3'd3, 1'b0, 1'b1);
        chk("rl.timeout_wb", 32'(if_rdy.mem_timeout), 32'h0);
        step();
        chk("rl.fetch", 32'(if_rdy.state_out), 32'h0);
        chk("rl.timeout_fetch", 32'(if_rdy.mem_timeout), 32'h0);

        // mem_ready exactly on the timeout cycle: ready wins
        step();
        chk("rc.exec", 32'(if_rdy.state_out), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rc.wait", 32'(if_rdy.state_out), 32'h2);
            if (i == 4) if_rdy.mem_ready = 1'b1;
        end
        step();
        if_rdy.mem_ready = 1'b0;
        chk("rc.wb", 32'(if_rdy.state_out), 32'h3);
        chk("rc.timeout", 32'(if_rdy.mem_timeout), 32'h0);
        step();
        chk("rc.timeout_fetch", 32'(if_rdy.mem_timeout), 32'h0);

        // STORE with no ready: 5 MEM_WAIT cycles then timeout pulse
        if_rdy.opcode = OP_STORE;
        step();
        chk3("rs.exec", if_rdy.state_out, if_rdy.pc_stall, if_rdy.reg_write_en, 3'd1, 1'b1, 1'b0);
        chk("rs.lanes", 32'(if_rdy.mem_write_en), 32'hF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk3("rs.wait", if_rdy.state_out, if_rdy.pc_stall, if_rdy.reg_write_en, 3'd2, 1'b1, 1'b0);
            chk("rs.wait_lanes", 32'(if_rdy.mem_write_en), 32'h0);
            chk("rs.wait_read", 32'(if_rdy.read_enable), 32'h0);
            chk("rs.wait_timeout", 32'(if_rdy.mem_timeout), 32'h0);
        end
        step();
        if_rdy.opcode = OP_NOP;
        chk3("rs.fetch", if_rdy.state_out, if_rdy.pc_stall, if_rdy.reg_write_en, 3'd0, 1'b1, 1'b0);
        chk("rs.timeout_pulse", 32'(if_rdy.mem_timeout), 32'h1);
        step();
        chk("rs.timeout_clear", 32'(if_rdy.mem_timeout), 32'h0);
        chk("rs.after_rwe", 32'(if_rdy.reg_write_en), 32'h0);

        // HALT, resume asserted in the 11th HALTED cycle
        if_fix.opcode = OP_HALT;
        do_reset();
        step();
        chk("h.exec_state", 32'(if_fix.state_out), 32'h1);
        chk("h.halt_now", 32'(if_fix.halt_now), 32'h1);
        chk("h.exec_stall", 32'(if_fix.pc_stall), 32'h1);
        chk("h.exec_halt", 32'(if_fix.halt), 32'h0);
        halt_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            chk3("h.halted", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd4, 1'b1, 1'b0);
            chk("h.halted_halt_now", 32'(if_fix.halt_now), 32'h0);
            if (if_fix.halt === 1'b1) halt_cnt++;
            if (i == 10) begin
                if_fix.resume = 1'b1;
                if_fix.opcode = OP_NOP;
            end
        end
        step();
        chk("h.halt_cycles", 32'(halt_cnt), 32'd11);
        chk3("h.resumed", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        chk("h.halt_cleared", 32'(if_fix.halt), 32'h0);
        step();
        if_fix.resume = 1'b0;
        chk("h.resume_ignored", 32'(if_fix.state_out), 32'h1);
        chk("h.halt_stays0", 32'(if_fix.halt), 32'h0);

        // Reset during MEM_WAIT of a load
        if_fix.opcode = OP_LOAD;
        do_reset();
        step();
        step();
        chk("rst.in_wait", 32'(if_fix.state_out), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk3("rst.async", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        chk("rst.read", 32'(if_fix.read_enable), 32'h0);
        step();
        chk("rst.held_rwe", 32'(if_fix.reg_write_en), 32'h0);
        if_fix.opcode = OP_R; if_fix.funct = 4'b0011;
        rst = 1'b0;
        chk3("rst.release", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd0, 1'b1, 1'b0);
        step();
        chk3("rst.exec", if_fix.state_out, if_fix.pc_stall, if_fix.reg_write_en, 3'd1, 1'b0, 1'b1);
        chk("rst.alu_op", 32'(if_fix.alu_op), 32'h3);
        step();
        chk("rst.back_fetch", 32'(if_fix.state_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
